// File: rtl/dag_pkg.sv
// Shared types and sizes for the DAG pipeline (node_id_mapper, topological_sort, dag_path_counter).
package dag_pkg;

    localparam int MAX_NODES       = 1024;
    localparam int NODE_IDX_WIDTH  = 10;
    localparam int MAX_EDGES       = 2048;
    localparam int EDGE_IDX_WIDTH  = 11;
    localparam int COUNT_WIDTH     = 16;

    typedef logic [NODE_IDX_WIDTH-1:0] node_idx_t;
    typedef logic [EDGE_IDX_WIDTH-1:0] edge_idx_t;
    typedef logic [COUNT_WIDTH-1:0]    count_t;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_LOAD,
        ST_SEED,
        ST_ORDER,
        ST_FETCH,
        ST_EDGE_RD,
        ST_CNT_RD,
        ST_CNT_WR,
        ST_RES_RD,
        ST_RES_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency, read-old on collision).
module sdp_ram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dag_path_counter.sv
// Counts paths start_node -> end_node over a loaded DAG, walking nodes in topological order.
// Build option: PATH_COUNT_SATURATE_EN makes the count adder clamp at all-ones instead of wrapping.
module dag_path_counter #(
    parameter int MAX_NODES      = dag_pkg::MAX_NODES,
    parameter int NODE_IDX_WIDTH = $clog2(MAX_NODES),
    parameter int MAX_EDGES      = dag_pkg::MAX_EDGES
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ready,
    input  logic                      decoding_done,
    input  logic                      src_node_valid,
    input  logic                      edge_valid,
    input  logic [NODE_IDX_WIDTH-1:0] src_node,
    input  logic [NODE_IDX_WIDTH-1:0] dst_node,
    input  logic [NODE_IDX_WIDTH-1:0] start_node,
    input  logic [NODE_IDX_WIDTH-1:0] end_node,
    input  logic                      order_valid,
    output logic                      order_ready,
    input  logic [NODE_IDX_WIDTH-1:0] order_node,
    input  logic                      order_last,
    output logic                      result_valid,
    output dag_pkg::count_t           result_data,
    output logic                      error
);

    import dag_pkg::*;

    localparam int EIDX_W = $clog2(MAX_EDGES);
    localparam int PTR_W  = EIDX_W + 1;
    localparam logic [PTR_W-1:0]          EDGE_FULL = PTR_W'(MAX_EDGES);
    localparam logic [NODE_IDX_WIDTH-1:0] LAST_NODE = NODE_IDX_WIDTH'(MAX_NODES - 1);

    function automatic count_t add_count(input count_t a, input count_t b);
`ifdef PATH_COUNT_SATURATE_EN
        logic [COUNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    state_t                    state_q, state_d;
    logic [NODE_IDX_WIDTH-1:0] init_addr_q, init_addr_d;
    logic                      ready_q, ready_d;
    logic                      error_q, error_d;
    logic                      chk_q, chk_d;
    logic                      dup_q, dup_d;
    logic                      last_q, last_d;
    logic                      res_vld_q, res_vld_d;
    count_t                    result_q, result_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          base_ptr_q, base_ptr_d;
    logic [PTR_W-1:0]          cur_cnt_q, cur_cnt_d;
    logic [PTR_W-1:0]          eptr_q, eptr_d;
    logic [PTR_W-1:0]          erem_q, erem_d;
    count_t                    node_cnt_q, node_cnt_d;
    logic [NODE_IDX_WIDTH-1:0] dst_q, dst_d;

    logic                      cnt_we;
    logic [NODE_IDX_WIDTH-1:0] cnt_waddr, cnt_raddr;
    count_t                    cnt_wdata, cnt_rdata;
    logic                      ec_we;
    logic [NODE_IDX_WIDTH-1:0] ec_waddr, ec_raddr;
    logic [PTR_W-1:0]          ec_wdata, ec_rdata;
    logic                      fe_we;
    logic [NODE_IDX_WIDTH-1:0] fe_waddr, fe_raddr;
    logic [PTR_W-1:0]          fe_wdata, fe_rdata;
    logic                      em_we;
    logic [EIDX_W-1:0]         em_waddr, em_raddr;
    logic [NODE_IDX_WIDTH-1:0] em_wdata, em_rdata;

    logic                      edge_dup;
    logic [PTR_W-1:0]          edge_base, edge_cnt_n;

    sdp_ram #(.DEPTH(MAX_NODES), .WIDTH(COUNT_WIDTH)) u_count (
        .clk(clk), .we(cnt_we), .waddr(cnt_waddr), .wdata(cnt_wdata), .raddr(cnt_raddr), .rdata(cnt_rdata)
    );
    sdp_ram #(.DEPTH(MAX_NODES), .WIDTH(PTR_W)) u_edge_cnt (
        .clk(clk), .we(ec_we), .waddr(ec_waddr), .wdata(ec_wdata), .raddr(ec_raddr), .rdata(ec_rdata)
    );
    sdp_ram #(.DEPTH(MAX_NODES), .WIDTH(PTR_W)) u_first_edge (
        .clk(clk), .we(fe_we), .waddr(fe_waddr), .wdata(fe_wdata), .raddr(fe_raddr), .rdata(fe_rdata)
    );
    sdp_ram #(.DEPTH(MAX_EDGES), .WIDTH(NODE_IDX_WIDTH)) u_edge_mem (
        .clk(clk), .we(em_we), .waddr(em_waddr), .wdata(em_wdata), .raddr(em_raddr), .rdata(em_rdata)
    );

    // An edge in the same cycle as its src_node_valid opens a fresh source line; otherwise the
    // duplicate verdict comes straight off the edge_cnt read issued one cycle earlier.
    assign edge_dup   = src_node_valid ? 1'b0 : (chk_q ? (ec_rdata != '0) : dup_q);
    assign edge_base  = src_node_valid ? wr_ptr_q : base_ptr_q;
    assign edge_cnt_n = (src_node_valid ? '0 : cur_cnt_q) + PTR_W'(1);

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        ready_d     = ready_q;
        error_d     = error_q;
        chk_d       = chk_q;
        dup_d       = dup_q;
        last_d      = last_q;
        res_vld_d   = res_vld_q;
        result_d    = result_q;
        wr_ptr_d    = wr_ptr_q;
        base_ptr_d  = base_ptr_q;
        cur_cnt_d   = cur_cnt_q;
        eptr_d      = eptr_q;
        erem_d      = erem_q;
        node_cnt_d  = node_cnt_q;
        dst_d       = dst_q;
        cnt_we = 1'b0; cnt_waddr = '0; cnt_wdata = '0; cnt_raddr = '0;
        ec_we  = 1'b0; ec_waddr  = '0; ec_wdata  = '0; ec_raddr  = '0;
        fe_we  = 1'b0; fe_waddr  = '0; fe_wdata  = '0; fe_raddr  = '0;
        em_we  = 1'b0; em_waddr  = '0; em_wdata  = '0; em_raddr  = '0;

        if (!ready_q && (edge_valid || src_node_valid || order_valid)) begin
            error_d = 1'b1;
        end
        if (chk_q) begin
            chk_d = 1'b0;
            dup_d = (ec_rdata != '0);
            if (ec_rdata != '0) begin
                error_d = 1'b1;
            end
        end

        case (state_q)
            ST_INIT: begin
                cnt_we = 1'b1; cnt_waddr = init_addr_q;
                ec_we  = 1'b1; ec_waddr  = init_addr_q;
                fe_we  = 1'b1; fe_waddr  = init_addr_q;
                init_addr_d = init_addr_q + 1'b1;
                wr_ptr_d    = '0;
                if (init_addr_q == LAST_NODE) begin
                    ready_d = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (src_node_valid) begin
                    ec_raddr   = src_node;
                    chk_d      = 1'b1;
                    dup_d      = 1'b0;
                    base_ptr_d = wr_ptr_q;
                    cur_cnt_d  = '0;
                end
                if (edge_valid && !edge_dup) begin
                    if (wr_ptr_q == EDGE_FULL) begin
                        error_d = 1'b1;
                    end else begin
                        em_we = 1'b1; em_waddr = wr_ptr_q[EIDX_W-1:0]; em_wdata = dst_node;
                        ec_we = 1'b1; ec_waddr = src_node; ec_wdata = edge_cnt_n;
                        fe_we = 1'b1; fe_waddr = src_node; fe_wdata = edge_base;
                        cur_cnt_d = edge_cnt_n;
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                    end
                end
                if (decoding_done) begin
                    state_d = ST_SEED;
                end
            end
            ST_SEED: begin
                cnt_we = 1'b1; cnt_waddr = start_node; cnt_wdata = count_t'(1);
                state_d = ST_ORDER;
            end
            ST_ORDER: begin
                if (order_valid) begin
                    cnt_raddr = order_node;
                    ec_raddr  = order_node;
                    fe_raddr  = order_node;
                    last_d    = order_last;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                node_cnt_d = cnt_rdata;
                erem_d     = ec_rdata;
                eptr_d     = fe_rdata;
                if (cnt_rdata == '0 || ec_rdata == '0) begin
                    state_d = last_q ? ST_RES_RD : ST_ORDER;
                end else begin
                    state_d = ST_EDGE_RD;
                end
            end
            // Fanout is read-edge, read-count, write-count; strictly one edge in flight.
            ST_EDGE_RD: begin
                em_raddr = eptr_q[EIDX_W-1:0];
                state_d  = ST_CNT_RD;
            end
            ST_CNT_RD: begin
                cnt_raddr = em_rdata;
                dst_d     = em_rdata;
                state_d   = ST_CNT_WR;
            end
            ST_CNT_WR: begin
                cnt_we = 1'b1; cnt_waddr = dst_q; cnt_wdata = add_count(cnt_rdata, node_cnt_q);
                eptr_d = eptr_q + 1'b1;
                erem_d = erem_q - 1'b1;
                if (erem_q == PTR_W'(1)) begin
                    state_d = last_q ? ST_RES_RD : ST_ORDER;
                end else begin
                    state_d = ST_EDGE_RD;
                end
            end
            ST_RES_RD: begin
                cnt_raddr = end_node;
                state_d   = ST_RES_WAIT;
            end
            ST_RES_WAIT: begin
                result_d  = cnt_rdata;
                res_vld_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            chk_q       <= 1'b0;
            dup_q       <= 1'b0;
            last_q      <= 1'b0;
            res_vld_q   <= 1'b0;
            result_q    <= '0;
            wr_ptr_q    <= '0;
            base_ptr_q  <= '0;
            cur_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            chk_q       <= chk_d;
            dup_q       <= dup_d;
            last_q      <= last_d;
            res_vld_q   <= res_vld_d;
            result_q    <= result_d;
            wr_ptr_q    <= wr_ptr_d;
            base_ptr_q  <= base_ptr_d;
            cur_cnt_q   <= cur_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        eptr_q     <= eptr_d;
        erem_q     <= erem_d;
        node_cnt_q <= node_cnt_d;
        dst_q      <= dst_d;
    end

    assign ready        = ready_q;
    assign order_ready  = (state_q == ST_ORDER);
    assign result_valid = res_vld_q;
    assign result_data  = result_q;
    assign error        = error_q;

endmodule

// File: tb/tb_dag_path_counter.sv
// Randomized and directed bench for dag_path_counter against a path-count model; a second
// instance with MAX_EDGES=4 sees the same stimulus to cover edge-memory overflow.
module tb_dag_path_counter;

    localparam int NIW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           decoding_done = 1'b0, src_node_valid = 1'b0, edge_valid = 1'b0;
    logic [NIW-1:0] src_node = '0, dst_node = '0, start_node = '0, end_node = '0, order_node = '0;
    logic           order_valid = 1'b0, order_valid_s = 1'b0, order_last = 1'b0;

    logic        ready, order_ready, result_valid, error;
    logic [15:0] result_data;
    logic        ready_s, order_ready_s, result_valid_s, error_s;
    logic [15:0] result_data_s;

    dag_path_counter u_dut (
        .clk(clk), .rst(rst), .ready(ready), .decoding_done(decoding_done),
        .src_node_valid(src_node_valid), .edge_valid(edge_valid), .src_node(src_node),
        .dst_node(dst_node), .start_node(start_node), .end_node(end_node),
        .order_valid(order_valid), .order_ready(order_ready), .order_node(order_node),
        .order_last(order_last), .result_valid(result_valid), .result_data(result_data),
        .error(error)
    );

    dag_path_counter #(.MAX_EDGES(4)) u_small (
        .clk(clk), .rst(rst), .ready(ready_s), .decoding_done(decoding_done),
        .src_node_valid(src_node_valid), .edge_valid(edge_valid), .src_node(src_node),
        .dst_node(dst_node), .start_node(start_node), .end_node(end_node),
        .order_valid(order_valid_s), .order_ready(order_ready_s), .order_node(order_node),
        .order_last(order_last), .result_valid(result_valid_s), .result_data(result_data_s),
        .error(error_s)
    );

    int n_pass  = 0;
    int n_total = 0;

    int e_src[$];
    int e_dst[$];
    int ord[$];
    int g_start, g_end;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic int model_add(input int a, input int b);
`ifdef PATH_COUNT_SATURATE_EN
        return (a + b > 65535) ? 65535 : a + b;
`else
        return (a + b) % 65536;
`endif
    endfunction

    // Path counts by dynamic programming over the given order, using only the first max_e edges.
    function automatic int model(input int max_e);
        int cnt[1024];
        int kept;
        foreach (cnt[i]) cnt[i] = 0;
        cnt[g_start] = 1;
        kept = (e_src.size() < max_e) ? e_src.size() : max_e;
        foreach (ord[k])
            for (int i = 0; i < kept; i++)
                if (e_src[i] == ord[k]) cnt[e_dst[i]] = model_add(cnt[e_dst[i]], cnt[ord[k]]);
        return cnt[g_end];
    endfunction

    task automatic add_edge(input int s, input int d);
        e_src.push_back(s);
        e_dst.push_back(d);
    endtask

    task automatic set_order(input int n);
        ord.delete();
        for (int i = 0; i < n; i++) ord.push_back(i);
    endtask

    task automatic build_diamond();
        e_src.delete(); e_dst.delete();
        add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!(ready && ready_s) && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, {31'd0, ready && ready_s}, 32'd1);
    endtask

    task automatic deliver();
        for (int i = 0; i < e_src.size(); i++) begin
            if (i == 0 || e_src[i] != e_src[i-1]) begin
                src_node = NIW'(e_src[i]); src_node_valid = 1'b1;
                @(negedge clk);
                src_node_valid = 1'b0;
            end
            dst_node = NIW'(e_dst[i]); edge_valid = 1'b1;
            @(negedge clk);
            edge_valid = 1'b0;
        end
        decoding_done = 1'b1;
        @(negedge clk);
        decoding_done = 1'b0;
    endtask

    task automatic send_order(input int node, input bit last);
        bit pm = 1'b1, ps = 1'b1, acc_m, acc_s;
        int n = 0;
        order_node = NIW'(node); order_last = last;
        order_valid = 1'b1; order_valid_s = 1'b1;
        while ((pm || ps) && n < 400) begin
            acc_m = pm && order_ready;
            acc_s = ps && order_ready_s;
            @(negedge clk);
            n++;
            if (acc_m) begin pm = 1'b0; order_valid = 1'b0; end
            if (acc_s) begin ps = 1'b0; order_valid_s = 1'b0; end
        end
        if (pm || ps) begin
            check_eq("order_handshake", {30'd0, pm, ps}, 32'd0);
            order_valid = 1'b0; order_valid_s = 1'b0;
        end
    endtask

    task automatic run_graph(input string tag, input bit with_reset);
        int n = 0;
        start_node = NIW'(g_start);
        end_node   = NIW'(g_end);
        if (with_reset) do_reset();
        wait_ready(tag);
        deliver();
        foreach (ord[k]) send_order(ord[k], k == ord.size() - 1);
        while (!(result_valid && result_valid_s) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"},   {31'd0, result_valid},   32'd1);
        check_eq({tag, "_valid_s"}, {31'd0, result_valid_s}, 32'd1);
        check_eq({tag, "_data"},    {16'd0, result_data},    32'(model(2048)));
        check_eq({tag, "_data_s"},  {16'd0, result_data_s},  32'(model(4)));
        check_eq({tag, "_error"},   {31'd0, error},          32'd0);
        check_eq({tag, "_error_s"}, {31'd0, error_s},        {31'd0, e_src.size() > 4});
    endtask

    initial begin
        bit saw_vld;
        int nn;

        // Reset state and INIT duration
        repeat (3) @(negedge clk);
        check_eq("rst_ready",        {31'd0, ready},        32'd0);
        check_eq("rst_order_ready",  {31'd0, order_ready},  32'd0);
        check_eq("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check_eq("rst_result_data",  {16'd0, result_data},  32'd0);
        check_eq("rst_error",        {31'd0, error},        32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (k == 1 || k == 1023) check_eq("init_ready_low", {31'd0, ready}, 32'd0);
            if (k == 1024)           check_eq("init_ready_high", {31'd0, ready}, 32'd1);
        end
        check_eq("init_error", {31'd0, error}, 32'd0);

        // Input during INIT is dropped and flagged
        do_reset();
        repeat (5) @(negedge clk);
        dst_node = '0; edge_valid = 1'b1;
        @(negedge clk);
        edge_valid = 1'b0;
        wait_ready("early");
        check_eq("early_error",   {31'd0, error},   32'd1);
        check_eq("early_error_s", {31'd0, error_s}, 32'd1);

        build_diamond(); set_order(4); g_start = 0; g_end = 3;
        run_graph("diamond", 1'b1);
        check_eq("diamond_const", {16'd0, result_data}, 32'd2);

        build_diamond(); set_order(5); g_start = 0; g_end = 4;
        run_graph("isolated", 1'b1);
        check_eq("isolated_const", {16'd0, result_data}, 32'd0);

        e_src.delete(); e_dst.delete();
        for (int d = 0; d < 16; d++) begin
            add_edge(3*d, 3*d + 1); add_edge(3*d, 3*d + 2);
            add_edge(3*d + 1, 3*d + 3); add_edge(3*d + 2, 3*d + 3);
        end
        set_order(49); g_start = 0; g_end = 48;
        run_graph("chain16", 1'b1);
`ifdef PATH_COUNT_SATURATE_EN
        check_eq("chain16_const", {16'd0, result_data}, 32'h0000_FFFF);
`else
        check_eq("chain16_const", {16'd0, result_data}, 32'd0);
`endif

        build_diamond(); add_edge(3, 4); set_order(5); g_start = 0; g_end = 4;
        run_graph("overflow", 1'b1);
        check_eq("overflow_small_const", {16'd0, result_data_s}, 32'd0);

        // Reset in the middle of fanout, then rerun after INIT
        build_diamond(); set_order(4); g_start = 0; g_end = 3;
        start_node = '0; end_node = NIW'(3);
        do_reset();
        wait_ready("midrst_pre");
        deliver();
        send_order(0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_ready", {31'd0, ready}, 32'd0);
        saw_vld = 1'b0;
        nn = 0;
        while (!ready && nn < 1100) begin
            if (result_valid) saw_vld = 1'b1;
            @(negedge clk);
            nn++;
        end
        check_eq("midrst_no_result", {31'd0, saw_vld}, 32'd0);
        run_graph("midrst_rerun", 1'b0);

        for (int r = 0; r < 4; r++) begin
            int nodes;
            nodes = $urandom_range(4, 12);
            e_src.delete(); e_dst.delete();
            for (int s = 0; s < nodes - 1; s++)
                for (int d = s + 1; d < nodes; d++)
                    if ($urandom_range(0, 2) == 0) add_edge(s, d);
            set_order(nodes);
            g_start = $urandom_range(0, 1);
            g_end   = $urandom_range(nodes / 2, nodes - 1);
            run_graph($sformatf("rand%0d", r), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
